// File: rtl/nibble_serial_mult8.sv
// Sequential 8x8 multiplier: walks the four nibble pairs of the operands through
// one 4x4 LUT multiplier and accumulates the shifted partial products.

module nibble_lut_mult4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] y
);
    // 4x4 product table, realised as a small combinational multiply
    assign y = {4'd0, a} * {4'd0, b};
endmodule

module nibble_serial_mult8 #(
    parameter bit SIGNED_MODE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  m_q;
    logic [7:0]  n_q;
    logic        neg_q;
    logic [1:0]  step_q;
    logic [15:0] acc_q;
    logic [15:0] p_q;
    logic        out_valid_q;
    logic        in_ready_q;
    logic        busy_q;

    logic [3:0]  lut_a_s;
    logic [3:0]  lut_b_s;
    logic [7:0]  lut_y_s;
    logic [15:0] term_s;
    logic [15:0] acc_d;
    logic [15:0] res_d;

    // -128 has no positive 8-bit signed form, so magnitudes are kept unsigned
    function automatic logic [7:0] mag8(input logic [7:0] x);
        if (SIGNED_MODE && x[7]) begin
            return (~x) + 8'd1;
        end else begin
            return x;
        end
    endfunction

    nibble_lut_mult4 u_lut (
        .a (lut_a_s),
        .b (lut_b_s),
        .y (lut_y_s)
    );

    // Nibble selection, partial-product alignment and result sign fix-up
    always_comb begin
        lut_a_s = m_q[3:0];
        lut_b_s = n_q[3:0];
        term_s  = 16'd0;
        if (step_q[1]) begin
            lut_a_s = m_q[7:4];
        end else begin
            lut_a_s = m_q[3:0];
        end
        if (step_q[0]) begin
            lut_b_s = n_q[7:4];
        end else begin
            lut_b_s = n_q[3:0];
        end
        case (step_q)
            2'd0:    term_s = {8'd0, lut_y_s};
            2'd1:    term_s = {8'd0, lut_y_s} << 4'd4;
            2'd2:    term_s = {8'd0, lut_y_s} << 4'd4;
            2'd3:    term_s = {8'd0, lut_y_s} << 4'd8;
            default: term_s = 16'd0;
        endcase
        acc_d = acc_q + term_s;
        if (neg_q) begin
            res_d = (~acc_d) + 16'd1;
        end else begin
            res_d = acc_d;
        end
    end

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            m_q         <= 8'd0;
            n_q         <= 8'd0;
            neg_q       <= 1'b0;
            step_q      <= 2'd0;
            acc_q       <= 16'd0;
            p_q         <= 16'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        m_q        <= mag8(a);
                        n_q        <= mag8(b);
                        neg_q      <= SIGNED_MODE ? (a[7] ^ b[7]) : 1'b0;
                        acc_q      <= 16'd0;
                        step_q     <= 2'd0;
                        state_q    <= S_CALC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_CALC: begin
                    acc_q  <= acc_d;
                    step_q <= step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        state_q     <= S_DONE;
                        p_q         <= res_d;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign p         = p_q;
    assign busy      = busy_q;
endmodule
